// File: rtl/rom_pixel_streamer.sv
// rom_pixel_streamer: reads a registered-output pixel ROM from address 0 upward
// and emits one frame as a valid/ready pixel stream with SOF/EOL sidebands.
// A 2-entry buffer absorbs the ROM's 1-cycle read latency under backpressure.
//
// Handshake: a pixel transfers on a rising edge where m_valid & m_ready. Once
// m_valid is high it stays high, with m_data/m_sof/m_eol stable, until that
// transfer happens. The producer side (ROM reads) is throttled so that buffered
// pixels plus the read in flight never exceed two.
module rom_pixel_streamer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int H_PIXELS   = 256,
  parameter int V_LINES    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  busy,
  output logic                  done
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES  > 1) ? $clog2(V_LINES)  : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;

  // Issue-side counters and the sidebands travelling with the in-flight read.
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          inflight_q;
  logic [2:0]    inflight_flags_q;   // {eof, eol, sof}

  // 2-entry output FIFO.
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [2:0]            buf_flags_q [2];   // {eof, eol, sof}
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;

  logic       x_last, y_last, last_addr;
  logic       pop, pop_eof, issue;
  logic [1:0] occ;

  assign x_last    = (x_q == XW'(H_PIXELS - 1));
  assign y_last    = (y_q == YW'(V_LINES - 1));
  assign last_addr = x_last & y_last;

  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign pop_eof = pop & buf_flags_q[rd_ptr_q][2];
  assign occ     = cnt_q + {1'b0, inflight_q};
  // A slot is free now, or one is being freed by this cycle's transfer.
  assign issue   = (state_q == S_RUN) &
                   ((occ < 2'd2) | ((occ == 2'd2) & pop));

  assign m_data = buf_data_q[rd_ptr_q];
  assign m_sof  = m_valid & buf_flags_q[rd_ptr_q][0];
  assign m_eol  = m_valid & buf_flags_q[rd_ptr_q][1];
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

  // FSM next-state and done-pulse generation.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      // A start coinciding with the done pulse is ignored: the frame that just
      // finished is still being reported.
      S_IDLE:  if (start && !done_q) state_d = S_RUN;
      S_RUN:   if (issue && last_addr) state_d = S_DRAIN;
      S_DRAIN: if (pop_eof) begin
                 state_d = S_IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // ROM read issue: advance address and raster counters, tag the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr         <= '0;
      x_q              <= '0;
      y_q              <= '0;
      inflight_q       <= 1'b0;
      inflight_flags_q <= 3'b000;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_flags_q <= {last_addr, x_last, (x_q == '0) && (y_q == '0)};
        rom_addr         <= last_addr ? '0 : rom_addr + ADDR_WIDTH'(1);
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Output FIFO: capture the ROM word the cycle after issue, pop on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0]  <= '0;
      buf_data_q[1]  <= '0;
      buf_flags_q[0] <= 3'b000;
      buf_flags_q[1] <= 3'b000;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q]  <= rom_rd_data;
        buf_flags_q[wr_ptr_q] <= inflight_flags_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
